// File: rtl/shift_reg_pkg.sv
// Shared types for the universal shift register: operation codes and burst FSM states.
// The helper function picks out the operations that move bits and may run as a burst.
package shift_reg_pkg;

    typedef enum logic [2:0] {
        HOLD = 3'b000,
        LOAD = 3'b001,
        SHL  = 3'b010,
        SHR  = 3'b011,
        ROL  = 3'b100,
        ROR  = 3'b101,
        ASR  = 3'b110,
        CLR  = 3'b111
    } mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Operations that shift a bit out (update ser_out) and are eligible for bursts
    function automatic logic is_burst_op(input mode_t m);
        return (m inside {SHL, SHR, ROL, ROR, ASR});
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-step next value for the universal shift register.
// out_bit is the bit leaving the register; it is only meaningful for shift/rotate modes.
module shift_step
    import shift_reg_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  mode_t            mode,
    input  logic [WIDTH-1:0] q,
    input  logic             ser_in,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] next_q,
    output logic             out_bit
);

    always_comb begin
        next_q  = q;
        out_bit = 1'b0;
        unique case (mode)
            HOLD: next_q = q;
            LOAD: next_q = d;
            SHL: begin
                next_q  = {q[WIDTH-2:0], ser_in};
                out_bit = q[WIDTH-1];
            end
            SHR: begin
                next_q  = {ser_in, q[WIDTH-1:1]};
                out_bit = q[0];
            end
            ROL: begin
                next_q  = {q[WIDTH-2:0], q[WIDTH-1]};
                out_bit = q[WIDTH-1];
            end
            ROR: begin
                next_q  = {q[0], q[WIDTH-1:1]};
                out_bit = q[0];
            end
            ASR: begin
                next_q  = {q[WIDTH-1], q[WIDTH-1:1]};
                out_bit = q[0];
            end
            CLR: next_q = RESET_VAL;
            default: next_q = q;
        endcase
    end

endmodule

// File: rtl/shift_reg_universal.sv
// WIDTH-bit universal shift register with single-step modes and a multi-cycle
// shift/rotate burst engine reporting progress through busy and a one-cycle done pulse.
module shift_reg_universal
    import shift_reg_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int              CNT_W     = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             ser_in,
    input  logic             start,
    input  logic [CNT_W-1:0] shamt,
    output logic [WIDTH-1:0] q,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    state_t           state_reg, state_next;
    mode_t            op_reg, op_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [WIDTH-1:0] q_reg, q_next;
    logic             ser_out_reg, ser_out_next;
    logic             busy_reg, done_reg;

    mode_t            live_mode;
    mode_t            step_mode;
    logic [WIDTH-1:0] step_q;
    logic             step_bit;

    assign live_mode = mode_t'(mode);
    // During a burst the latched operation drives the datapath, never the live mode
    assign step_mode = (state_reg == RUN) ? op_reg : live_mode;

    shift_step #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_step (
        .mode    (step_mode),
        .q       (q_reg),
        .ser_in  (ser_in),
        .d       (d),
        .next_q  (step_q),
        .out_bit (step_bit)
    );

    always_comb begin
        state_next   = state_reg;
        op_next      = op_reg;
        cnt_next     = cnt_reg;
        q_next       = q_reg;
        ser_out_next = ser_out_reg;
        unique case (state_reg)
            IDLE: begin
                if (start && is_burst_op(live_mode)) begin
                    if (shamt == '0) begin
                        state_next = DONE;
                    end else begin
                        q_next       = step_q;
                        ser_out_next = step_bit;
                        op_next      = live_mode;
                        cnt_next     = shamt - CNT_W'(1);
                        state_next   = (shamt == CNT_W'(1)) ? DONE : RUN;
                    end
                end else begin
                    q_next = step_q;
                    if (is_burst_op(live_mode)) begin
                        ser_out_next = step_bit;
                    end
                end
            end
            RUN: begin
                q_next       = step_q;
                ser_out_next = step_bit;
                cnt_next     = cnt_reg - CNT_W'(1);
                if (cnt_reg == CNT_W'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            op_reg      <= HOLD;
            cnt_reg     <= '0;
            q_reg       <= RESET_VAL;
            ser_out_reg <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else if (en) begin
            state_reg   <= state_next;
            op_reg      <= op_next;
            cnt_reg     <= cnt_next;
            q_reg       <= q_next;
            ser_out_reg <= ser_out_next;
            busy_reg    <= (state_next == RUN);
            done_reg    <= (state_next == DONE);
        end
    end

    assign q       = q_reg;
    assign ser_out = ser_out_reg;
    assign busy    = busy_reg;
    assign done    = done_reg;

endmodule

// File: tb/tb_shift_reg_universal.sv
// Directed bench for shift_reg_universal: an arithmetic reference model is compared on
// every falling edge, and hand-computed literal expectations pin the key results.
module tb_shift_reg_universal;

    localparam int         W  = 8;
    localparam logic [7:0] RV = 8'h3C;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic [2:0] mode = 3'd0;
    logic [7:0] d = 8'h00;
    logic       ser_in = 1'b0;
    logic       start = 1'b0;
    logic [3:0] shamt = 4'd0;
    logic [7:0] q;
    logic       ser_out;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    shift_reg_universal #(
        .WIDTH     (W),
        .RESET_VAL (RV)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .mode    (mode),
        .d       (d),
        .ser_in  (ser_in),
        .start   (start),
        .shamt   (shamt),
        .q       (q),
        .ser_out (ser_out),
        .busy    (busy),
        .done    (done)
    );

    // Reference model: register value as an unsigned number, burst as a steps-left count
    function automatic logic [7:0] f_q(input logic [2:0] op, input logic [7:0] v,
                                       input logic si, input logic [7:0] dd);
        int vi;
        int s;
        vi = int'(v);
        s  = int'(si);
        case (op)
            3'd1:    return dd;
            3'd2:    return 8'((vi * 2 + s) % 256);
            3'd3:    return 8'(vi / 2 + s * 128);
            3'd4:    return 8'((vi * 2) % 256 + vi / 128);
            3'd5:    return 8'(vi / 2 + (vi % 2) * 128);
            3'd6:    return 8'(vi / 2 + (vi / 128) * 128);
            3'd7:    return RV;
            default: return v;
        endcase
    endfunction

    function automatic logic f_bit(input logic [2:0] op, input logic [7:0] v);
        int vi;
        vi = int'(v);
        if (op == 3'd2 || op == 3'd4) return (vi / 128) != 0;
        return (vi % 2) != 0;
    endfunction

    function automatic bit moves_bits(input logic [2:0] op);
        return (op >= 3'd2) && (op <= 3'd6);
    endfunction

    logic [7:0] m_q;
    logic       m_ser;
    logic       m_busy;
    logic       m_done;
    logic [2:0] m_op;
    int         m_left;

    always @(posedge clk) begin
        if (reset) begin
            m_q    <= RV;
            m_ser  <= 1'b0;
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_op   <= 3'd0;
            m_left <= 0;
        end else if (en) begin
            if (m_busy) begin
                m_q    <= f_q(m_op, m_q, ser_in, d);
                m_ser  <= f_bit(m_op, m_q);
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                end
            end else if (m_done) begin
                m_done <= 1'b0;
            end else if (start && moves_bits(mode)) begin
                if (shamt == 4'd0) begin
                    m_done <= 1'b1;
                end else begin
                    m_q    <= f_q(mode, m_q, ser_in, d);
                    m_ser  <= f_bit(mode, m_q);
                    m_op   <= mode;
                    m_left <= int'(shamt) - 1;
                    if (shamt == 4'd1) m_done <= 1'b1;
                    else               m_busy <= 1'b1;
                end
            end else begin
                m_q <= f_q(mode, m_q, ser_in, d);
                if (moves_bits(mode)) m_ser <= f_bit(mode, m_q);
            end
        end
    end

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        $display("t=%0t en=%b mode=%0d start=%b shamt=%0d -> q=%h ser_out=%b busy=%b done=%b",
                 $time, en, mode, start, shamt, q, ser_out, busy, done);
    endtask

    task automatic do_load(input logic [7:0] v);
        mode  = 3'd1;
        d     = v;
        start = 1'b0;
        tick();
        mode = 3'd0;
    endtask

    task automatic burst(input logic [2:0] op, input logic [3:0] n);
        mode  = op;
        shamt = n;
        start = 1'b1;
        tick();
        start = 1'b0;
        mode  = 3'd0;
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        while (done !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        check1("burst_done_seen", done, 1'b1);
    endtask

    initial begin
        fork
            begin
                forever begin
                    @(negedge clk);
                    if (chk_on) begin
                        check8("model_q", q, m_q);
                        check1("model_ser_out", ser_out, m_ser);
                        check1("model_busy", busy, m_busy);
                        check1("model_done", done, m_done);
                    end
                end
            end
            begin
                // Reset state
                tick();
                tick();
                reset  = 1'b0;
                en     = 1'b1;
                chk_on = 1'b1;
                check8("reset_q", q, RV);
                check1("reset_ser_out", ser_out, 1'b0);
                check1("reset_busy", busy, 1'b0);
                check1("reset_done", done, 1'b0);

                // Load then hold
                do_load(8'hA5);
                check8("load_a5", q, 8'hA5);
                tick(); tick(); tick();
                check8("hold_a5", q, 8'hA5);

                // ROL burst of 3 on 0x81
                do_load(8'h81);
                burst(3'd4, 4'd3);
                check8("rol_step1", q, 8'h03);
                check1("rol_busy1", busy, 1'b1);
                tick();
                check1("rol_busy2", busy, 1'b1);
                tick();
                check8("rol3_q", q, 8'h0C);
                check1("rol3_done", done, 1'b1);
                check1("rol3_busy", busy, 1'b0);
                check1("rol3_ser_out", ser_out, 1'b0);
                tick();
                check1("rol3_done_clears", done, 1'b0);

                // ASR by WIDTH on 0x80, then SHR by WIDTH with zero fill
                do_load(8'h80);
                burst(3'd6, 4'd8);
                wait_done(12);
                check8("asr8_q", q, 8'hFF);
                tick();
                do_load(8'h80);
                ser_in = 1'b0;
                burst(3'd3, 4'd8);
                wait_done(12);
                check8("shr8_q", q, 8'h00);
                check1("shr8_ser_out", ser_out, 1'b1);
                tick();

                // SHL burst with a two-cycle stall
                do_load(8'h01);
                burst(3'd2, 4'd4);
                check8("shl_step1", q, 8'h02);
                tick();
                check8("shl_step2", q, 8'h04);
                en = 1'b0;
                tick();
                tick();
                check8("stall_q", q, 8'h04);
                check1("stall_busy", busy, 1'b1);
                en = 1'b1;
                tick();
                check1("stall_not_done", done, 1'b0);
                tick();
                check8("shl4_q", q, 8'h10);
                check1("shl4_done", done, 1'b1);
                tick();

                // Zero-length burst, start held through DONE, then start with a load
                mode  = 3'd2;
                shamt = 4'd0;
                start = 1'b1;
                tick();
                check8("shamt0_q", q, 8'h10);
                check1("shamt0_done", done, 1'b1);
                check1("shamt0_busy", busy, 1'b0);
                tick();
                check1("start_in_done_ignored", done, 1'b0);
                check8("start_in_done_q", q, 8'h10);
                mode  = 3'd1;
                d     = 8'h77;
                shamt = 4'd3;
                tick();
                start = 1'b0;
                mode  = 3'd0;
                check8("start_load_q", q, 8'h77);
                check1("start_load_busy", busy, 1'b0);
                check1("start_load_done", done, 1'b0);
                tick();
                check1("start_load_no_done", done, 1'b0);

                // ROL by WIDTH and by more than WIDTH
                do_load(8'hB4);
                burst(3'd4, 4'd8);
                wait_done(12);
                check8("rol8_q", q, 8'hB4);
                tick();
                burst(3'd4, 4'd10);
                wait_done(14);
                check8("rol10_q", q, 8'hD2);
                tick();

                // Reset in the middle of a ROR burst
                do_load(8'h96);
                burst(3'd5, 4'd5);
                tick();
                check1("ror_mid_busy", busy, 1'b1);
                reset = 1'b1;
                tick();
                reset = 1'b0;
                check8("midreset_q", q, RV);
                check1("midreset_busy", busy, 1'b0);
                check1("midreset_done", done, 1'b0);
                check1("midreset_ser_out", ser_out, 1'b0);
                tick();
                check1("midreset_no_done", done, 1'b0);
                do_load(8'hC3);
                check8("post_reset_load", q, 8'hC3);
                tick();
            end
        join_any
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
